cdb_arbiter: RTL and testbench

- Sits directly downstream of the ALU reservation stations.
- Collects CDB write requests from NUM_PRODUCERS producers and grants at most one per cycle, using round-robin priority.
- Returns the one-cycle accepted handshake to the granted producer.
- Broadcasts the granted result on the common data bus one cycle later, tagged with the producer's CDB tag, to every listener.

---
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for common data bus (CDB) write requests.
//
// Several producers (ALU reservation stations) may each want to write a result
// to the CDB in the same cycle. At most one of them is granted per cycle, in
// round-robin order. The grant is combinational, so a producer sees its
// accepted handshake in the same cycle as its request. The granted result is
// then broadcast on the CDB one cycle later, tagged with that producer's tag.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        synchronous active-low reset; overrides every other input
//   cdb_enable   when 0, no grant is issued this cycle (bus stall)
//   req_in       bit i is producer i's write request
//   data_in      flattened producer results; producer i uses slice i
//   accepted_out one-hot-or-zero grant, one bit per producer
//   cdb_valid    registered broadcast valid
//   cdb_tag      registered broadcast tag (TAG_BASE + granted index)
//   cdb_data     registered broadcast data
module cdb_arbiter #(
   parameter int unsigned DATA_WIDTH    = 4,
   parameter int unsigned CDB_TAG_WIDTH = 4,
   parameter int unsigned NUM_PRODUCERS = 4,
   parameter int unsigned TAG_BASE      = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                cdb_enable,
   input  logic [NUM_PRODUCERS-1:0]            req_in,
   input  logic [NUM_PRODUCERS*DATA_WIDTH-1:0] data_in,
   output logic [NUM_PRODUCERS-1:0]            accepted_out,
   output logic                                cdb_valid,
   output logic [CDB_TAG_WIDTH-1:0]            cdb_tag,
   output logic [DATA_WIDTH-1:0]               cdb_data
);

   localparam int unsigned PtrW = $clog2(NUM_PRODUCERS);

   // ptr_q is the highest-priority producer index for the current cycle.
   logic [PtrW-1:0]          ptr_q, ptr_d;
   logic                     cdb_valid_q;
   logic [CDB_TAG_WIDTH-1:0] cdb_tag_q;
   logic [DATA_WIDTH-1:0]    cdb_data_q;

   logic                     grant_valid;
   logic [PtrW-1:0]          grant_idx;
   logic [DATA_WIDTH-1:0]    grant_data;
   logic [CDB_TAG_WIDTH-1:0] grant_tag;
   int                       cand;

   // Scan from ptr_q upward with wrap-around; the first requester found wins.
   // Gating with rst_n keeps producers from releasing reservations in reset.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      if (rst_n && cdb_enable) begin
         for (int i = 0; i < int'(NUM_PRODUCERS); i++) begin
            cand = (int'(ptr_q) + i) % int'(NUM_PRODUCERS);
            if (!grant_valid && req_in[cand]) begin
               grant_valid = 1'b1;
               grant_idx   = PtrW'(cand);
            end
         end
      end
   end

   always_comb begin
      accepted_out = '0;
      if (grant_valid) begin
         accepted_out[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      grant_data = data_in[int'(grant_idx)*int'(DATA_WIDTH) +: DATA_WIDTH];
      grant_tag  = CDB_TAG_WIDTH'(TAG_BASE + int'(grant_idx));
      // The producer just served drops to lowest priority next time.
      if (int'(grant_idx) == int'(NUM_PRODUCERS) - 1) begin
         ptr_d = '0;
      end else begin
         ptr_d = grant_idx + PtrW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
      end else if (grant_valid) begin
         ptr_q       <= ptr_d;
         cdb_valid_q <= 1'b1;
         cdb_tag_q   <= grant_tag;
         cdb_data_q  <= grant_data;
      end else begin
         // Tag and data hold; only valid drops so each result is seen once.
         cdb_valid_q <= 1'b0;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios followed by random traffic.
// Two instances share the inputs; the second uses TAG_BASE=8. A driver applies
// stimulus, checks the combinational grant against a reference model and
// queues the expected broadcast; a monitor pops and compares broadcasts.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int TW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cdb_enable = 1'b0;
   logic [N-1:0]    req_in = '0;
   logic [N*DW-1:0] data_in = '0;

   logic [N-1:0]    acc_a, acc_b;
   logic            valid_a, valid_b;
   logic [TW-1:0]   tag_a, tag_b;
   logic [DW-1:0]   data_a, data_b;

   cdb_arbiter #(
      .DATA_WIDTH(DW), .CDB_TAG_WIDTH(TW), .NUM_PRODUCERS(N), .TAG_BASE(0)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .cdb_enable(cdb_enable), .req_in(req_in),
      .data_in(data_in), .accepted_out(acc_a), .cdb_valid(valid_a),
      .cdb_tag(tag_a), .cdb_data(data_a)
   );

   cdb_arbiter #(
      .DATA_WIDTH(DW), .CDB_TAG_WIDTH(TW), .NUM_PRODUCERS(N), .TAG_BASE(8)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .cdb_enable(cdb_enable), .req_in(req_in),
      .data_in(data_in), .accepted_out(acc_b), .cdb_valid(valid_b),
      .cdb_tag(tag_b), .cdb_data(data_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            g;
      logic [DW-1:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_ptr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   // Reference: first requester at or after the priority index, with wrap.
   function automatic int model_grant(input logic r, input logic e, input logic [N-1:0] q);
      if (!r || !e) return -1;
      for (int k = 0; k < N; k++) begin
         if (q[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   // One cycle of stimulus. want: -2 no directed check, -1 no grant, else index.
   // late_rst drops rst_n after the grant is observed, so the edge ending this
   // cycle is a reset edge that must discard the just-granted broadcast.
   task automatic step(input logic r, input logic e, input logic [N-1:0] q,
                       input logic [N*DW-1:0] d, input int want, input bit late_rst);
      int           g;
      logic [N-1:0] exp_acc;
      @(posedge clk);
      #2;
      rst_n = r; cdb_enable = e; req_in = q; data_in = d;
      #2;
      g = model_grant(r, e, q);
      exp_acc = (g >= 0) ? (N'(1) << g) : '0;
      check("accepted", acc_a, exp_acc);
      check("accepted_tagbase8", acc_b, exp_acc);
      if (want != -2) check("directed_grant", acc_a, (want >= 0) ? (32'd1 << want) : 32'd0);
      if (!r) begin
         m_ptr = 0;
      end else if (g >= 0) begin
         m_ptr = (g + 1) % N;
         exp_q.push_back('{g: g, d: d[g*DW +: DW]});
      end
      if (late_rst) begin
         #2;
         rst_n = 1'b0;
         m_ptr = 0;
         if (g >= 0) void'(exp_q.pop_back());
      end
   endtask

   // Monitor: samples just after each rising edge, before the driver moves.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (valid_a === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_broadcast", 32'(valid_a), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("cdb_tag", tag_a, e.g);
               check("cdb_data", data_a, e.d);
               check("cdb_valid_tagbase8", valid_b, 1);
               check("cdb_tag_tagbase8", tag_b, (8 + e.g) % 16);
               check("cdb_data_tagbase8", data_b, e.d);
            end
         end else begin
            check("missing_broadcast", exp_q.size(), 0);
            check("idle_valid_tagbase8", valid_b, 0);
            exp_q.delete();
         end
      end
   end

   initial begin
      // 1: reset with all requests held; grants must stay masked.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1111, 16'hFFFF, -1, 1'b0);
      step(1'b1, 1'b1, 4'b0000, 16'h0000, -1, 1'b0);
      check("reset_valid", valid_a, 0);
      check("reset_tag", tag_a, 0);
      check("reset_data", data_a, 0);

      // 2: single requester, broadcast for exactly one cycle.
      step(1'b1, 1'b1, 4'b0100, 16'h0A00, 2, 1'b0);
      step(1'b1, 1'b1, 4'b0000, 16'h0000, -1, 1'b0);
      check("single_valid", valid_a, 1);
      check("single_tag", tag_a, 2);
      check("single_data", data_a, 4'hA);
      step(1'b1, 1'b1, 4'b0000, 16'h0000, -1, 1'b0);
      check("single_valid_drop", valid_a, 0);

      // 3: round-robin from a fresh pointer.
      step(1'b0, 1'b1, 4'b0000, 16'h0000, -1, 1'b0);
      step(1'b1, 1'b1, 4'b1111, 16'h8765, 0, 1'b0);
      step(1'b1, 1'b1, 4'b1111, 16'h8765, 1, 1'b0);
      step(1'b1, 1'b1, 4'b1111, 16'h8765, 2, 1'b0);
      step(1'b1, 1'b1, 4'b1111, 16'h8765, 3, 1'b0);
      step(1'b1, 1'b1, 4'b1111, 16'h8765, 0, 1'b0);

      // 4: priority wrap.
      step(1'b1, 1'b1, 4'b1000, 16'h3000, 3, 1'b0);
      step(1'b1, 1'b1, 4'b1010, 16'h40C0, 1, 1'b0);
      step(1'b1, 1'b1, 4'b1010, 16'h50D0, 3, 1'b0);

      // 5: stall, then release.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0001, 16'h0009, -1, 1'b0);
      step(1'b1, 1'b1, 4'b0001, 16'h0009, 0, 1'b0);
      step(1'b1, 1'b1, 4'b0000, 16'h0000, -1, 1'b0);
      check("stall_release_tag_b", tag_b, 8);

      // 6: reset lands on the edge after a grant to producer 1.
      step(1'b1, 1'b1, 4'b0010, 16'h00E0, 1, 1'b1);
      step(1'b1, 1'b1, 4'b0011, 16'h0021, 0, 1'b0);
      check("midreset_valid", valid_a, 0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(99) >= 3) ? 1'b1 : 1'b0,
              ($urandom_range(4) != 0) ? 1'b1 : 1'b0,
              N'($urandom), (N*DW)'($urandom), -2,
              ($urandom_range(99) == 0) ? 1'b1 : 1'b0);
      end
      step(1'b1, 1'b1, 4'b0000, 16'h0000, -1, 1'b0);
      step(1'b1, 1'b1, 4'b0000, 16'h0000, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
